// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller in front of the CP0 external interrupt input.
// External lines are synchronised and edge-detected. A compare timer adds one
// more source. Pending sources are masked, and a one-cycle request pulse goes
// out. Further requests are held off until CP0 signals ERET.
module irq_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      data_w,
  output logic [31:0]      data_r,
  input  logic             eret,
  output logic             ir_out,
  output logic [3:0]       irq_id
);

  localparam int W = N_SRC + 1;  // external lines plus the timer bit

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAISE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic [N_SRC-1:0] sync0_r, sync1_r, prev_r, rise_r;
  logic [W-1:0]     pend_r, mask_r, pend_next_s, set_s, clr_s, active_s;
  logic [31:0]      cmp_r, cnt_r;
  logic             match_s, wr_pend_s, wr_mask_s, wr_cmp_s, wr_cnt_s;
  state_t           state_r, state_next_s;
  logic             ir_out_r, ir_next_s;
  logic [3:0]       irq_id_r, id_next_s;

  // Lowest set index of a W-bit vector (0 when empty).
  function automatic logic [3:0] lowest_idx(input logic [W-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  assign wr_pend_s = we && (addr == 2'd0);
  assign wr_mask_s = we && (addr == 2'd1);
  assign wr_cmp_s  = we && (addr == 2'd2);
  assign wr_cnt_s  = we && (addr == 2'd3);

  // Two-flop synchroniser, previous-value flop and a registered rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_r <= '0;
      sync1_r <= '0;
      prev_r  <= '0;
      rise_r  <= '0;
    end else begin
      sync0_r <= src_in;
      sync1_r <= sync0_r;
      prev_r  <= sync1_r;
      rise_r  <= sync1_r & ~prev_r;
    end
  end

  // Timer match and pending update; a set beats a same-cycle W1C.
  always_comb begin
    match_s     = (cmp_r != 32'd0) && (cnt_r == cmp_r);
    set_s       = {match_s && !wr_cnt_s, rise_r};
    if (wr_pend_s) clr_s = data_w[W-1:0];
    else           clr_s = {W{1'b0}};
    pend_next_s = (pend_r & ~clr_s) | set_s;
  end

  // Software-visible registers: pending, mask, compare and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
      mask_r <= '0;
      cmp_r  <= 32'd0;
      cnt_r  <= 32'd0;
    end else begin
      pend_r <= pend_next_s;
      if (wr_mask_s) mask_r <= data_w[W-1:0];
      if (wr_cmp_s)  cmp_r  <= data_w;
      if (wr_cnt_s)               cnt_r <= data_w;      // a load beats a match
      else if (cmp_r == 32'd0)    cnt_r <= cnt_r;       // timer disabled
      else if (match_s)           cnt_r <= 32'd0;
      else                        cnt_r <= cnt_r + 32'd1;
    end
  end

  // Request FSM next state, pulse and source latch.
  always_comb begin
    state_next_s = state_r;
    ir_next_s    = 1'b0;
    id_next_s    = irq_id_r;
    active_s     = pend_r & mask_r;
    case (state_r)
      ST_IDLE: begin
        if (active_s != {W{1'b0}}) begin
          state_next_s = ST_RAISE;
          ir_next_s    = 1'b1;
          id_next_s    = lowest_idx(active_s);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RAISE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (eret) state_next_s = ST_IDLE;
        else      state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      ir_out_r <= 1'b0;
      irq_id_r <= 4'd0;
    end else begin
      state_r  <= state_next_s;
      ir_out_r <= ir_next_s;
      irq_id_r <= id_next_s;
    end
  end

  assign ir_out = ir_out_r;
  assign irq_id = irq_id_r;

  // Zero-latency register read mux; unimplemented upper bits read as 0.
  always_comb begin
    case (addr)
      2'd0:    data_r = {{(32 - W){1'b0}}, pend_r};
      2'd1:    data_r = {{(32 - W){1'b0}}, mask_r};
      2'd2:    data_r = cmp_r;
      2'd3:    data_r = cnt_r;
      default: data_r = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and randomized checks of irq_ctrl against a
// behavioural model built on sample history and a request token.
module tb_irq_ctrl;

  localparam int N = 4;
  localparam logic [31:0] WMASK = 32'h1F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [N-1:0] src_in = '0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] data_w = 32'd0;
  logic        eret = 1'b0;
  logic [31:0] data_r;
  logic        ir_out;
  logic [3:0]  irq_id;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  // model state
  logic [31:0] m_pend, m_mask, m_cmp, m_cnt;
  logic [N-1:0] h1, h2, h3, h4;   // src samples, h1 = most recent edge
  bit          m_free, m_ir;
  logic [3:0]  m_id;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .rst(rst), .src_in(src_in), .addr(addr), .we(we),
    .data_w(data_w), .data_r(data_r), .eret(eret), .ir_out(ir_out),
    .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_pend;
      2'd1:    return m_mask;
      2'd2:    return m_cmp;
      default: return m_cnt;
    endcase
  endfunction

  function automatic logic [3:0] lowest(input logic [31:0] v);
    for (int i = 0; i <= N; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_cmp = 0; m_cnt = 0;
    h1 = '0; h2 = '0; h3 = '0; h4 = '0;
    m_free = 1'b1; m_ir = 1'b0; m_id = 4'd0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic [31:0] pend_o, mask_o, cmp_o, cnt_o, clr, tbit;
    logic [N-1:0] rise;
    bit tmatch, wcnt, ir_o;
    pend_o = m_pend; mask_o = m_mask; cmp_o = m_cmp; cnt_o = m_cnt;
    rise   = h3 & ~h4;               // sampled 0 then 1, three edges back
    tmatch = (cmp_o != 0) && (cnt_o == cmp_o);
    wcnt   = we && (addr == 2'd3);
    ir_o   = m_ir;
    m_ir   = 1'b0;
    if (m_free && ((pend_o & mask_o) != 0)) begin
      m_ir = 1'b1; m_id = lowest(pend_o & mask_o); m_free = 1'b0;
    end else if (!m_free && !ir_o && eret) begin
      m_free = 1'b1;
    end
    clr  = (we && addr == 2'd0) ? (data_w & WMASK) : 32'd0;
    tbit = (tmatch && !wcnt) ? (32'd1 << N) : 32'd0;
    m_pend = (pend_o & ~clr) | {28'd0, rise} | tbit;
    if (we && addr == 2'd1) m_mask = data_w & WMASK;
    if (we && addr == 2'd2) m_cmp = data_w;
    if (wcnt)              m_cnt = data_w;
    else if (cmp_o == 0)   m_cnt = cnt_o;
    else if (tmatch)       m_cnt = 0;
    else                   m_cnt = cnt_o + 1;
    h4 = h3; h3 = h2; h2 = h1; h1 = src_in;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    chk("ir_out", {31'd0, ir_out}, {31'd0, m_ir});
    chk("irq_id", {28'd0, irq_id}, {28'd0, m_id});
    chk("data_r", data_r, m_read(addr));
    if (ir_out) pulses++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; data_w = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a;
    #1;
    chk("read", data_r, m_read(a));
  endtask

  task automatic eret_pulse();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic wait_ir(input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      step();
      if (ir_out) got = 1'b1;
    end
    chk("wait_ir", {31'd0, got}, 32'd1);
  endtask

  initial begin
    m_reset();
    // reset state
    step();
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1 chk("reset_read", data_r, 32'd0);
    end
    rst = 1'b0;

    // single source request
    wr(2'd1, 32'h1);
    src_in = 4'h1; step(); src_in = 4'h0;
    addr = 2'd0;
    repeat (2) step();
    step();
    chk("pend_k3", data_r, 32'h1);
    repeat (4) step();
    chk("one_pulse", pulses, 1);
    chk("id0", {28'd0, irq_id}, 32'd0);

    // no second pulse without eret; then re-request of the uncleared bit
    wr(2'd1, 32'h5);
    src_in = 4'h4; step(); src_in = 4'h0;
    repeat (8) step();
    chk("held_off", pulses, 1);
    eret_pulse();
    repeat (4) step();
    chk("rerequest", pulses, 2);
    chk("rerequest_id", {28'd0, irq_id}, 32'd0);
    wr(2'd0, 32'h1);
    eret_pulse();
    repeat (4) step();
    chk("second_src", pulses, 3);
    chk("second_src_id", {28'd0, irq_id}, 32'd2);

    // compare timer
    wr(2'd0, 32'h1FF);
    eret_pulse();
    wr(2'd1, 32'h1 << N);
    wr(2'd2, 32'd5);
    addr = 2'd3;
    for (int k = 0; k < 3; k++) begin
      wait_ir(20);
      chk("timer_id", {28'd0, irq_id}, N);
      wr(2'd0, 32'h1 << N);
      eret_pulse();
      addr = 2'd3;
    end
    wr(2'd2, 32'd0);

    // same-cycle W1C and edge on line 1: set wins
    wr(2'd0, 32'h1FF);
    wr(2'd1, 32'd0);
    eret_pulse();
    src_in = 4'h2; step(); src_in = 4'h0;
    repeat (5) step();
    src_in = 4'h2; step(); step(); step();
    addr = 2'd0; we = 1'b1; data_w = 32'h2;
    step();
    we = 1'b0; src_in = 4'h0;
    chk("set_beats_w1c", data_r & 32'h2, 32'h2);

    // same-cycle CNT write and match: write wins, nothing pended
    wr(2'd0, 32'h1FF);
    wr(2'd3, 32'd5);
    wr(2'd2, 32'd5);
    wr(2'd3, 32'h100);
    chk("cnt_wr_wins", data_r, 32'h100);
    rd(2'd0);
    chk("no_timer_pend", data_r & (32'h1 << N), 32'd0);
    wr(2'd2, 32'd0);

    // held-high line pends once
    wr(2'd0, 32'h1FF);
    addr = 2'd0;
    src_in = 4'h2;
    repeat (5) step();
    chk("held_set", data_r & 32'h2, 32'h2);
    wr(2'd0, 32'h2);
    repeat (15) step();
    chk("held_once", data_r & 32'h2, 32'd0);
    src_in = 4'h0; repeat (4) step();
    src_in = 4'h2; repeat (5) step();
    chk("re_edge", data_r & 32'h2, 32'h2);
    src_in = 4'h0;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      src_in = 4'($urandom);
      addr   = 2'($urandom);
      we     = ($urandom_range(0, 7) == 0);
      eret   = ($urandom_range(0, 4) == 0);
      if (addr == 2'd2)      data_w = $urandom_range(0, 12);
      else if (addr == 2'd3) data_w = $urandom_range(0, 15);
      else                   data_w = $urandom;
      step();
    end
    we = 1'b0; eret = 1'b0; src_in = 4'h0;

    // asynchronous reset during WAIT
    wr(2'd2, 32'd0);
    wr(2'd1, 32'd0);
    repeat (5) step();
    wr(2'd0, 32'h1FF);
    eret_pulse();
    src_in = 4'hF; step(); src_in = 4'h0;
    repeat (5) step();
    rd(2'd0);
    chk("pend_f", data_r, 32'hF);
    wr(2'd1, 32'hF);
    repeat (3) step();
    #2 rst = 1'b1;
    m_reset();
    #1 chk("rst_ir_out", {31'd0, ir_out}, 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a));
    step();
    rst = 1'b0;
    wr(2'd1, 32'h8);
    src_in = 4'h8; step(); src_in = 4'h0;
    wait_ir(10);
    chk("post_rst_id", {28'd0, irq_id}, 32'd3);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
